// File: rtl/serial_receiver_cfg_pkg.sv
// Shared serial-line definitions: receiver/transmitter state encodings and parity modes.
package serial_receiver_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    DONE  = 3'd5
  } serial_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // data_xor is the XOR of all data bits; odd mode expects a total of ones that is odd
  function automatic logic parity_bad(input logic data_xor, input logic pbit, input int mode);
    return (data_xor ^ pbit) != (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Down-counting bit-period timer: load a count, get a one-cycle pulse when it reaches zero.
module serial_bit_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;
  logic         armed;

  always_ff @(posedge clock) begin
    if (!reset_) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= load_val;
      armed <= 1'b1;
    end else begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      if (expire)    armed <= 1'b0;
    end
  end

  // armed keeps the pulse single-shot while the count rests at zero
  assign expire = armed && (cnt == '0);

endmodule

// File: rtl/serial_receiver_cfg.sv
// UART-style receiver: oversampled start/data/parity/stop recovery with a dav_/rfd consumer handshake.
module serial_receiver_cfg
  import serial_receiver_cfg_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int BIT_CYCLES = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 reset_,
  input  logic                 rxd,
  input  logic                 rfd,
  output logic                 dav_,
  output logic [DATA_BITS-1:0] data,
  output logic                 perr,
  output logic                 ferr,
  output logic                 ovr
);

  localparam int TW = $clog2(BIT_CYCLES);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LD = TW'(BIT_CYCLES / 2 - 1);
  localparam logic [TW-1:0] FULL_LD = TW'(BIT_CYCLES - 1);

  serial_state_e        state, state_n;
  logic                 rx_meta, rxs;
  logic                 tmr_load, expire;
  logic [TW-1:0]        tmr_val;
  logic [CW-1:0]        bit_cnt, cnt_ld_val;
  logic                 cnt_ld, cnt_dec;
  logic                 frame_go, shift_en, par_smp, stop_smp, frame_done;
  logic [DATA_BITS-1:0] shift;
  logic                 perr_n, ferr_n;
  logic                 consume;

  always_ff @(posedge clock) begin
    if (!reset_) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  serial_bit_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .reset_   (reset_),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (expire)
  );

  always_ff @(posedge clock) begin
    if (!reset_) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n    = state;
    tmr_load   = 1'b0;
    tmr_val    = FULL_LD;
    cnt_ld     = 1'b0;
    cnt_ld_val = CW'(STOP_BITS);
    cnt_dec    = 1'b0;
    frame_go   = 1'b0;
    shift_en   = 1'b0;
    par_smp    = 1'b0;
    stop_smp   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          tmr_load = 1'b1;
          tmr_val  = HALF_LD;
          state_n  = START;
        end
      end
      START: begin
        // mid start bit: a line already back high was only a glitch
        if (expire) begin
          if (rxs) begin
            state_n = IDLE;
          end else begin
            tmr_load   = 1'b1;
            cnt_ld     = 1'b1;
            cnt_ld_val = CW'(DATA_BITS);
            frame_go   = 1'b1;
            state_n    = DATA;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shift_en = 1'b1;
          cnt_dec  = 1'b1;
          tmr_load = 1'b1;
          if (bit_cnt == CW'(1)) begin
            if (PARITY != PAR_NONE) begin
              state_n = PAR;
            end else begin
              cnt_ld  = 1'b1;
              state_n = STOP;
            end
          end
        end
      end
      PAR: begin
        if (expire) begin
          par_smp  = 1'b1;
          tmr_load = 1'b1;
          cnt_ld   = 1'b1;
          state_n  = STOP;
        end
      end
      STOP: begin
        if (expire) begin
          stop_smp = 1'b1;
          cnt_dec  = 1'b1;
          if (bit_cnt == CW'(1)) state_n  = DONE;
          else                   tmr_load = 1'b1;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      shift   <= '0;
      bit_cnt <= '0;
      perr_n  <= 1'b0;
      ferr_n  <= 1'b0;
    end else begin
      if (cnt_ld)                     bit_cnt <= cnt_ld_val;
      else if (cnt_dec && bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
      if (shift_en) shift <= {rxs, shift[DATA_BITS-1:1]};
      if (frame_go) begin
        perr_n <= 1'b0;
        ferr_n <= 1'b0;
      end
      if (par_smp)           perr_n <= parity_bad(^shift, rxs, PARITY);
      if (stop_smp && !rxs)  ferr_n <= 1'b1;
    end
  end

  assign consume = rfd && !dav_;

  // a consuming rfd in the DONE cycle frees the slot for the frame just finished
  always_ff @(posedge clock) begin
    if (!reset_) begin
      dav_ <= 1'b1;
      data <= '0;
      perr <= 1'b0;
      ferr <= 1'b0;
      ovr  <= 1'b0;
    end else if (frame_done) begin
      if (dav_ || rfd) begin
        data <= shift;
        perr <= perr_n;
        ferr <= ferr_n;
        dav_ <= 1'b0;
      end else begin
        ovr <= 1'b1;
      end
      if (consume) ovr <= 1'b0;
    end else if (consume) begin
      dav_ <= 1'b1;
      perr <= 1'b0;
      ferr <= 1'b0;
      ovr  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_receiver_cfg.sv
// Scoreboard bench: 8N1 receiver (a) and 8E1 receiver (b) driven with random and directed frames.
module tb_serial_receiver_cfg;

  localparam int BC = 16;
  localparam int DB = 8;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_ = 1'b0;
  logic          rxd_a = 1'b1, rxd_b = 1'b1;
  logic          rfd_man = 1'b0, rfd_auto_a = 1'b0, rfd_b = 1'b0;
  logic          rfd_a;
  logic          dav_a, perr_a, ferr_a, ovr_a;
  logic          dav_b, perr_b, ferr_b, ovr_b;
  logic [DB-1:0] data_a, data_b;
  bit            auto_a = 1'b0;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  assign rfd_a = rfd_man | rfd_auto_a;

  serial_receiver_cfg #(.DATA_BITS(DB), .BIT_CYCLES(BC), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clock (clock), .reset_ (reset_), .rxd (rxd_a), .rfd (rfd_a),
    .dav_ (dav_a), .data (data_a), .perr (perr_a), .ferr (ferr_a), .ovr (ovr_a)
  );

  serial_receiver_cfg #(.DATA_BITS(DB), .BIT_CYCLES(BC), .PARITY(1), .STOP_BITS(1)) dut_b (
    .clock (clock), .reset_ (reset_), .rxd (rxd_b), .rfd (rfd_b),
    .dav_ (dav_b), .data (data_b), .perr (perr_b), .ferr (ferr_b), .ovr (ovr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  // consumers: acknowledge a presented frame one cycle later
  always begin
    @(posedge clock); #2;
    rfd_auto_a = auto_a && !dav_a && !rfd_auto_a;
    rfd_b      = !dav_b && !rfd_b;
  end

  // monitors: a load is dav_ falling, or dav_ staying low across a consuming rfd
  logic prev_dav_a = 1'b1, seen_rfd_a = 1'b0;
  logic prev_dav_b = 1'b1, seen_rfd_b = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (reset_ && !dav_a && (prev_dav_a || seen_rfd_a)) begin
      if (qa.size() == 0) flag_fail("a_spurious_frame", {24'h0, data_a});
      else begin
        e = qa.pop_front();
        check("a_data", {24'h0, data_a}, {24'h0, e.d});
        check("a_perr", {31'h0, perr_a}, {31'h0, e.pe});
        check("a_ferr", {31'h0, ferr_a}, {31'h0, e.fe});
      end
    end
    prev_dav_a = dav_a;
    seen_rfd_a = rfd_a;
  end

  always @(negedge clock) begin
    exp_t e;
    if (reset_ && !dav_b && (prev_dav_b || seen_rfd_b)) begin
      if (qb.size() == 0) flag_fail("b_spurious_frame", {24'h0, data_b});
      else begin
        e = qb.pop_front();
        check("b_data", {24'h0, data_b}, {24'h0, e.d});
        check("b_perr", {31'h0, perr_b}, {31'h0, e.pe});
        check("b_ferr", {31'h0, ferr_b}, {31'h0, e.fe});
      end
    end
    prev_dav_b = dav_b;
    seen_rfd_b = rfd_b;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_line(input int inst, input logic v);
    if (inst == 0) rxd_a = v;
    else           rxd_b = v;
  endtask

  // start bit, data LSB first, optional parity, one stop bit; line left idle high
  task automatic send_frame(input int inst, input logic [7:0] d, input bit use_par,
                            input logic pb, input logic stopb);
    logic [15:0] v;
    int n;
    v = '0;
    n = 1;
    for (int i = 0; i < DB; i++) begin v[n] = d[i]; n++; end
    if (use_par) begin v[n] = pb; n++; end
    v[n] = stopb;
    n++;
    for (int i = 0; i < n; i++) begin
      set_line(inst, v[i]);
      idle(BC);
    end
    set_line(inst, 1'b1);
  endtask

  task automatic push_a(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    qb.push_back(e);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_dav"},  {31'h0, dav_a},  32'h1);
    check({tag, "_data"}, {24'h0, data_a}, 32'h0);
    check({tag, "_perr"}, {31'h0, perr_a}, 32'h0);
    check({tag, "_ferr"}, {31'h0, ferr_a}, 32'h0);
    check({tag, "_ovr"},  {31'h0, ovr_a},  32'h0);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((qa.size() != 0 || qb.size() != 0) && k < 2000) begin
      @(posedge clock);
      k++;
    end
    #1;
    check({tag, "_pending_a"}, qa.size(), 0);
    check({tag, "_pending_b"}, qb.size(), 0);
  endtask

  initial begin
    logic [7:0] d;
    logic       sb, pb;

    idle(3);
    check_reset_a("rst_a");
    check("rst_b_dav", {31'h0, dav_b}, 32'h1);
    check("rst_b_ovr", {31'h0, ovr_b}, 32'h0);
    reset_ = 1'b1;
    idle(2);

    auto_a = 1'b1;
    push_a(8'hA5, 1'b0, 1'b0);
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    idle(3 * BC);
    check("a5_ovr", {31'h0, ovr_a}, 32'h0);

    // short low glitch must not start a frame
    rxd_a = 1'b0;
    idle(5);
    rxd_a = 1'b1;
    idle(3 * BC);
    check("glitch_dav", {31'h0, dav_a}, 32'h1);

    push_a(8'h5A, 1'b0, 1'b1);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0);
    idle(3 * BC);

    // line held low for about two frame times: two break frames
    push_a(8'h00, 1'b0, 1'b1);
    push_a(8'h00, 1'b0, 1'b1);
    rxd_a = 1'b0;
    idle(20 * BC - 6);
    rxd_a = 1'b1;
    idle(4 * BC);

    for (int i = 0; i < 16; i++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      push_a(d, 1'b0, !sb);
      send_frame(0, d, 1'b0, 1'b0, sb);
      idle($urandom_range(2 * BC, 4 * BC));
    end
    drain("rand_a");

    // overrun: second frame arrives while the first is still unread
    auto_a = 1'b0;
    idle(2);
    push_a(8'h11, 1'b0, 1'b0);
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    idle(2 * BC);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    idle(2 * BC);
    check("ovr_data", {24'h0, data_a}, 32'h11);
    check("ovr_flag", {31'h0, ovr_a}, 32'h1);
    check("ovr_dav",  {31'h0, dav_a}, 32'h0);

    // rfd landing in the DONE cycle of the next frame
    push_a(8'h22, 1'b0, 1'b0);
    fork
      send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
      begin
        repeat (3 + BC / 2 + BC * (DB + 1)) @(posedge clock);
        #1;
        rfd_man = 1'b1;
        check("coin_pre_dav", {31'h0, dav_a}, 32'h0);
        @(posedge clock);
        #1;
        rfd_man = 1'b0;
        check("coin_dav",  {31'h0, dav_a},  32'h0);
        check("coin_data", {24'h0, data_a}, 32'h22);
        check("coin_ovr",  {31'h0, ovr_a},  32'h0);
      end
    join
    idle(BC);
    rfd_man = 1'b1;
    idle(1);
    rfd_man = 1'b0;
    check("ack_dav", {31'h0, dav_a}, 32'h1);

    // leave a frame pending with ovr set, then reset in the middle of data bit 4
    push_a(8'h44, 1'b0, 1'b0);
    send_frame(0, 8'h44, 1'b0, 1'b0, 1'b1);
    idle(2 * BC);
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    idle(2 * BC);
    check("pre_rst_ovr", {31'h0, ovr_a}, 32'h1);
    fork
      send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1);
      begin
        repeat (BC * 5 + BC / 2) @(posedge clock);
        #1;
        reset_ = 1'b0;
        idle(1);
        check_reset_a("midrst");
        reset_ = 1'b1;
      end
    join
    qa.delete();
    idle(3 * BC);
    check("post_rst_dav", {31'h0, dav_a}, 32'h1);
    auto_a = 1'b1;
    push_a(8'h3C, 1'b0, 1'b0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    idle(3 * BC);

    // even parity receiver
    push_b(8'h07, 1'b1, 1'b0);
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    idle(2 * BC);
    push_b(8'h07, 1'b0, 1'b0);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    idle(2 * BC);
    for (int i = 0; i < 10; i++) begin
      d  = 8'($urandom);
      pb = 1'($urandom);
      push_b(d, ^{d, pb}, 1'b0);
      send_frame(1, d, 1'b1, pb, 1'b1);
      idle($urandom_range(2 * BC, 3 * BC));
    end
    drain("end");
    check("end_ovr_a", {31'h0, ovr_a}, 32'h0);
    check("end_ovr_b", {31'h0, ovr_b}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
